// File: rtl/hci_tcdm_bank_responder.sv
// Single-bank TCDM responder for one HCI memory-side lane.
// Requests are granted combinationally. Each transfer is answered one cycle
// after its grant. Test-and-set is a granted read followed by a one-cycle
// locked write of all-ones to the same word.
module hci_tcdm_bank_responder #(
  parameter int unsigned N_WORDS = 256,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned BW      = 8,
  parameter int unsigned UW      = 0,
  parameter int unsigned IW      = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       stall_i,
  input  logic                       req_i,
  input  logic [AW-1:0]              add_i,
  input  logic                       wen_i,
  input  logic [DW-1:0]              data_i,
  input  logic [DW/BW-1:0]           be_i,
  input  logic [(UW>0 ? UW : 1)-1:0] user_i,
  input  logic [IW-1:0]              id_i,
  input  logic                       ts_set_i,
  output logic                       gnt_o,
  output logic                       r_valid_o,
  output logic [DW-1:0]              r_data_o,
  output logic [(UW>0 ? UW : 1)-1:0] r_user_o,
  output logic [IW-1:0]              r_id_o
);

  localparam int unsigned NB   = DW / BW;
  localparam int unsigned IDXW = $clog2(N_WORDS);
  localparam int unsigned UWE  = (UW > 0) ? UW : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, TS_SET = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ts_idx_q, ts_idx_d;
  logic              r_valid_q, r_valid_d;
  logic [DW-1:0]     r_data_q, r_data_d;
  logic [UWE-1:0]    r_user_q, r_user_d;
  logic [IW-1:0]     r_id_q, r_id_d;

  logic [DW-1:0]     mem_q [N_WORDS];

  logic              soft_rst_s;
  logic              xfer_s;
  logic [IDXW-1:0]   idx_s;
  logic [UWE-1:0]    rd_user_s;
  logic              wr_en_s;
  logic [IDXW-1:0]   wr_idx_s;
  logic [DW-1:0]     wr_data_s;
  logic [NB-1:0]     wr_be_s;
  logic              wr_user_en_s;
  logic [UWE-1:0]    wr_user_s;
  logic              unused_addr_s;

  assign soft_rst_s    = rst_i | clear_i;
  assign idx_s         = add_i[IDXW+1:2];
  assign gnt_o         = req_i & ~stall_i & (state_q == IDLE);
  assign xfer_s        = req_i & gnt_o;
  assign unused_addr_s = ^{add_i[AW-1:IDXW+2], add_i[1:0]};

  // Next-state and response logic; a reset/clear drops any same-cycle transfer.
  always_comb begin
    state_d   = state_q;
    ts_idx_d  = ts_idx_q;
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    r_user_d  = r_user_q;
    r_id_d    = r_id_q;
    if (soft_rst_s) begin
      state_d   = IDLE;
      r_valid_d = 1'b0;
      r_data_d  = '0;
      r_user_d  = '0;
      r_id_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer_s && wen_i && ts_set_i) begin
            state_d  = TS_SET;
            ts_idx_d = idx_s;
          end else begin
            state_d  = IDLE;
          end
        end
        TS_SET:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (xfer_s) begin
        r_valid_d = 1'b1;
        r_id_d    = id_i;
        if (wen_i) begin
          r_data_d = mem_q[idx_s];
          r_user_d = rd_user_s;
        end else begin
          r_data_d = r_data_q;
          r_user_d = r_user_q;
        end
      end else begin
        r_valid_d = 1'b0;
      end
    end
  end

  // Single storage write port: the TS_SET set-write, otherwise a granted write.
  always_comb begin
    wr_en_s      = 1'b0;
    wr_idx_s     = idx_s;
    wr_data_s    = data_i;
    wr_be_s      = be_i;
    wr_user_en_s = 1'b0;
    wr_user_s    = user_i;
    if (soft_rst_s) begin
      wr_en_s      = 1'b0;
    end else if (state_q == TS_SET) begin
      wr_en_s      = 1'b1;
      wr_idx_s     = ts_idx_q;
      wr_data_s    = '1;
      wr_be_s      = '1;
      wr_user_en_s = 1'b1;
      wr_user_s    = '1;
    end else if (xfer_s && !wen_i) begin
      wr_en_s      = 1'b1;
      wr_user_en_s = (be_i != '0);
    end else begin
      wr_en_s      = 1'b0;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ts_idx_q  <= '0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_user_q  <= '0;
      r_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      ts_idx_q  <= ts_idx_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_user_q  <= r_user_d;
      r_id_q    <= r_id_d;
    end
  end

  // Byte-enabled data storage; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_s[b]) begin
          mem_q[wr_idx_s][b*BW +: BW] <= wr_data_s[b*BW +: BW];
        end
      end
    end
  end

  if (UW > 0) begin : g_user
    logic [UWE-1:0] umem_q [N_WORDS];

    // User-bit storage, written whole; not reset.
    always_ff @(posedge clk_i) begin
      if (wr_en_s && wr_user_en_s) begin
        umem_q[wr_idx_s] <= wr_user_s;
      end
    end

    assign rd_user_s = umem_q[idx_s];
  end else begin : g_no_user
    logic unused_user_s;
    assign unused_user_s = ^{user_i, wr_user_s, wr_user_en_s};
    assign rd_user_s     = '0;
  end

  assign r_valid_o = r_valid_q;
  assign r_data_o  = r_data_q;
  assign r_user_o  = r_user_q;
  assign r_id_o    = r_id_q;

endmodule

// File: tb/tb_hci_tcdm_bank_responder.sv
// Self-checking bench: a UW=0 instance (main) and a UW=4 instance (user bits)
// share all stimulus; outputs are compared against a word-array reference model.
module tb_hci_tcdm_bank_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, stall, req, wen, ts;
  logic [31:0] add, wdata;
  logic [3:0]  be, user;
  logic [19:0] id;
  logic [0:0]  user0;
  assign user0 = user[0:0];

  logic        gnt_a, rv_a, gnt_b, rv_b;
  logic [31:0] rdata_a, rdata_b;
  logic [0:0]  ruser_a;
  logic [3:0]  ruser_b;
  logic [19:0] rid_a, rid_b;

  hci_tcdm_bank_responder dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .stall_i(stall), .req_i(req),
    .add_i(add), .wen_i(wen), .data_i(wdata), .be_i(be), .user_i(user0),
    .id_i(id), .ts_set_i(ts), .gnt_o(gnt_a), .r_valid_o(rv_a),
    .r_data_o(rdata_a), .r_user_o(ruser_a), .r_id_o(rid_a));

  hci_tcdm_bank_responder #(.UW(4)) dut_u (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .stall_i(stall), .req_i(req),
    .add_i(add), .wen_i(wen), .data_i(wdata), .be_i(be), .user_i(user),
    .id_i(id), .ts_set_i(ts), .gnt_o(gnt_b), .r_valid_o(rv_b),
    .r_data_o(rdata_b), .r_user_o(ruser_b), .r_id_o(rid_b));

  // reference model: storage plus "set owed" flag and current response registers
  logic [31:0] m_mem [256];
  logic [3:0]  m_user [256];
  bit          m_busy = 1'b0;
  logic [7:0]  m_tsidx = 8'd0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [3:0]  m_ruser = 4'd0;
  logic [19:0] m_rid = 20'd0;

  logic        e_gnt, e_rv, o_gnt, o_rv;
  logic [31:0] e_rdata, o_rdata;
  logic [3:0]  e_ruser, o_ruser4;
  logic [0:0]  o_ruser0;
  logic [19:0] e_rid, o_rid;

  int checks = 0;
  int errors = 0;

  task automatic idle_in();
    req = 1'b0; wen = 1'b1; ts = 1'b0; stall = 1'b0; rst = 1'b0; clr = 1'b0;
    add = $urandom; wdata = $urandom; be = 4'($urandom); user = 4'($urandom); id = 20'($urandom);
  endtask

  task automatic set_rd(input int word, input logic [19:0] i, input logic t);
    req = 1'b1; wen = 1'b1; ts = t; id = i;
    add = {22'($urandom), 8'(word), 2'($urandom)};
  endtask

  task automatic set_wr(input int word, input logic [31:0] d, input logic [3:0] b,
                        input logic [19:0] i, input logic [3:0] u);
    req = 1'b1; wen = 1'b0; ts = 1'($urandom); id = i; wdata = d; be = b; user = u;
    add = {22'($urandom), 8'(word), 2'($urandom)};
  endtask

  // one clock cycle: sample outputs mid-cycle, snapshot expectations, advance the model
  task automatic tick();
    logic [7:0] idx;
    @(negedge clk);
    o_gnt = gnt_a; o_rv = rv_a; o_rdata = rdata_a; o_rid = rid_a;
    o_ruser0 = ruser_a; o_ruser4 = ruser_b;
    e_gnt = req & ~stall & ~m_busy;
    e_rv = m_rv; e_rdata = m_rdata; e_rid = m_rid; e_ruser = m_ruser;
    @(posedge clk);
    idx = add[9:2];
    if (rst | clr) begin
      m_busy = 1'b0; m_rv = 1'b0; m_rdata = 32'd0; m_ruser = 4'd0; m_rid = 20'd0;
    end else begin
      if (m_busy) begin
        m_mem[m_tsidx] = 32'hFFFF_FFFF; m_user[m_tsidx] = 4'hF; m_busy = 1'b0;
      end
      m_rv = e_gnt;
      if (e_gnt) begin
        m_rid = id;
        if (wen) begin
          m_rdata = m_mem[idx]; m_ruser = m_user[idx];
          if (ts) begin m_busy = 1'b1; m_tsidx = idx; end
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[b]) m_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
          if (be != 4'd0) m_user[idx] = user;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_in(); rst = 1'b1;
    tick(); tick();
    checks++; if (o_rv !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", o_rv); end
    checks++; if (o_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", o_rdata); end
    checks++; if (o_rid !== 20'd0) begin errors++; $display("FAIL reset_rid got %h want 0", o_rid); end
    checks++; if (o_ruser4 !== 4'd0 || o_ruser0 !== 1'b0) begin errors++; $display("FAIL reset_ruser got %h/%b want 0", o_ruser4, o_ruser0); end
    checks++; if (o_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", o_gnt); end
    idle_in(); set_wr(0, 32'd0, 4'd0, 20'd1, 4'd0);
    tick();
    checks++; if (o_gnt !== 1'b1) begin errors++; $display("FAIL post_reset_gnt got %b want 1", o_gnt); end
  endtask

  task automatic test_fill();
    for (int w = 0; w < 256; w++) begin
      idle_in(); set_wr(w, $urandom, 4'hF, 20'(w), 4'($urandom));
      tick();
      checks++;
      if (o_rv !== e_rv || o_rid !== e_rid) begin
        errors++; $display("FAIL fill_resp w%0d got %b/%h want %b/%h", w, o_rv, o_rid, e_rv, e_rid);
      end
    end
  endtask

  task automatic test_write_read();
    idle_in(); set_wr(5, 32'hDEAD_BEEF, 4'hF, 20'd3, 4'd0); tick();
    idle_in(); set_rd(5, 20'd7, 1'b0); tick();
    checks++; if (o_rv !== 1'b1 || o_rid !== 20'd3) begin errors++; $display("FAIL wr_resp got %b/%h want 1/3", o_rv, o_rid); end
    idle_in(); set_wr(5, 32'h1122_3344, 4'h5, 20'd8, 4'd0); tick();
    checks++; if (o_rv !== 1'b1 || o_rdata !== 32'hDEAD_BEEF || o_rid !== 20'd7) begin
      errors++; $display("FAIL rd_full got %b/%h/%h want 1/deadbeef/7", o_rv, o_rdata, o_rid); end
    idle_in(); set_rd(5, 20'd9, 1'b0); tick();
    checks++; if (o_rid !== 20'd8 || o_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_hold got %h/%h want 8/deadbeef", o_rid, o_rdata); end
    idle_in(); tick();
    checks++; if (o_rv !== 1'b1 || o_rdata !== 32'hDE22_BE44 || o_rid !== 20'd9) begin
      errors++; $display("FAIL rd_partial got %b/%h/%h want 1/de22be44/9", o_rv, o_rdata, o_rid); end
    idle_in(); tick();
    checks++; if (o_rv !== 1'b0 || o_rdata !== 32'hDE22_BE44) begin
      errors++; $display("FAIL idle_hold got %b/%h want 0/de22be44", o_rv, o_rdata); end
  endtask

  task automatic test_ts();
    idle_in(); set_wr(9, 32'h0000_0001, 4'hF, 20'd1, 4'h3); tick();
    idle_in(); set_rd(9, 20'd2, 1'b1); tick();
    checks++; if (o_gnt !== 1'b1) begin errors++; $display("FAIL ts_gnt got %b want 1", o_gnt); end
    idle_in(); set_rd(9, 20'd4, 1'b0); tick();
    checks++; if (o_gnt !== 1'b0) begin errors++; $display("FAIL ts_bubble_gnt got %b want 0", o_gnt); end
    checks++; if (o_rv !== 1'b1 || o_rdata !== 32'h0000_0001 || o_rid !== 20'd2) begin
      errors++; $display("FAIL ts_resp got %b/%h/%h want 1/00000001/2", o_rv, o_rdata, o_rid); end
    tick();
    checks++; if (o_gnt !== 1'b1 || o_rv !== 1'b0) begin errors++; $display("FAIL ts_after got gnt %b rv %b want 1/0", o_gnt, o_rv); end
    idle_in(); tick();
    checks++; if (o_rv !== 1'b1 || o_rdata !== 32'hFFFF_FFFF || o_rid !== 20'd4 || o_ruser4 !== 4'hF) begin
      errors++; $display("FAIL ts_set_read got %b/%h/%h/%h want 1/ffffffff/4/f", o_rv, o_rdata, o_rid, o_ruser4); end
  endtask

  task automatic test_stall_stream();
    int i = 0;
    int got = 0;
    for (int c = 0; c < 30; c++) begin
      idle_in();
      if (i < 8) set_rd(i, 20'(100 + i), 1'b0);
      stall = (c % 2) == 1;
      tick();
      checks++; if (o_gnt !== e_gnt || o_rv !== e_rv) begin
        errors++; $display("FAIL stall_gnt_rv c%0d got %b/%b want %b/%b", c, o_gnt, o_rv, e_gnt, e_rv); end
      if (o_rv === 1'b1) begin
        checks++;
        if (got >= 8) begin errors++; $display("FAIL stall_extra_resp c%0d got %h want none", c, o_rid); end
        else if (o_rid !== 20'(100 + got) || o_rdata !== m_mem[got]) begin
          errors++; $display("FAIL stall_order c%0d got %h/%h want %h/%h", c, o_rid, o_rdata, 20'(100 + got), m_mem[got]); end
        got++;
      end
      if (e_gnt) i++;
    end
    checks++; if (got != 8) begin errors++; $display("FAIL stall_count got %0d want 8", got); end
  endtask

  task automatic test_ts_reset();
    idle_in(); set_wr(3, 32'hA5A5_A5A5, 4'hF, 20'd1, 4'h2); tick();
    idle_in(); set_rd(3, 20'd5, 1'b1); tick();
    idle_in(); rst = 1'b1; tick();
    checks++; if (o_rv !== 1'b1 || o_rdata !== 32'hA5A5_A5A5 || o_rid !== 20'd5) begin
      errors++; $display("FAIL tsrst_resp got %b/%h/%h want 1/a5a5a5a5/5", o_rv, o_rdata, o_rid); end
    idle_in(); set_wr(3, 32'h0, 4'hF, 20'd6, 4'h0); rst = 1'b1; tick();
    checks++; if (o_rv !== 1'b0) begin errors++; $display("FAIL tsrst_rv got %b want 0", o_rv); end
    idle_in(); tick();
    checks++; if (o_rv !== 1'b0) begin errors++; $display("FAIL dropped_resp got %b want 0", o_rv); end
    idle_in(); set_rd(3, 20'd6, 1'b0); tick();
    checks++; if (o_gnt !== 1'b1) begin errors++; $display("FAIL tsrst_idle_gnt got %b want 1", o_gnt); end
    idle_in(); tick();
    checks++; if (o_rdata !== 32'hA5A5_A5A5 || o_rid !== 20'd6) begin
      errors++; $display("FAIL tsrst_read got %h/%h want a5a5a5a5/6", o_rdata, o_rid); end
  endtask

  task automatic test_user();
    idle_in(); set_wr(20, 32'h0102_0304, 4'hF, 20'd1, 4'h3); tick();
    idle_in(); set_wr(20, 32'h1234_5678, 4'h0, 20'd2, 4'hA); tick();
    idle_in(); set_rd(20, 20'd3, 1'b0); tick();
    idle_in(); tick();
    checks++; if (o_ruser4 !== 4'h3 || o_rdata !== 32'h0102_0304) begin
      errors++; $display("FAIL user_be0 got %h/%h want 3/01020304", o_ruser4, o_rdata); end
    idle_in(); set_wr(20, 32'h0000_00CC, 4'h1, 20'd4, 4'hA); tick();
    idle_in(); set_rd(20, 20'd5, 1'b0); tick();
    idle_in(); tick();
    checks++; if (o_ruser4 !== 4'hA || o_rdata !== 32'h0102_03CC || o_ruser0 !== 1'b0) begin
      errors++; $display("FAIL user_be1 got %h/%h/%b want a/010203cc/0", o_ruser4, o_rdata, o_ruser0); end
    idle_in(); set_rd(20, 20'd6, 1'b1); tick();
    idle_in(); tick();
    idle_in(); set_rd(20, 20'd7, 1'b0); tick();
    idle_in(); tick();
    checks++; if (o_ruser4 !== 4'hF || o_rdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL user_ts got %h/%h want f/ffffffff", o_ruser4, o_rdata); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle_in();
      if ($urandom_range(0, 99) < 75) begin
        if ($urandom_range(0, 1) == 1) set_rd($urandom_range(0, 15), 20'($urandom), 1'($urandom_range(0, 3) == 0));
        else set_wr($urandom_range(0, 15), $urandom, 4'($urandom), 20'($urandom), 4'($urandom));
      end
      stall = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 49) == 0;
      clr = $urandom_range(0, 49) == 0;
      tick();
      checks++; if (o_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %b want %b", c, o_gnt, e_gnt); end
      checks++; if (o_rv !== e_rv) begin errors++; $display("FAIL rnd_rv c%0d got %b want %b", c, o_rv, e_rv); end
      checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL rnd_rdata c%0d got %h want %h", c, o_rdata, e_rdata); end
      checks++; if (o_rid !== e_rid) begin errors++; $display("FAIL rnd_rid c%0d got %h want %h", c, o_rid, e_rid); end
      checks++; if (o_ruser4 !== e_ruser || o_ruser0 !== 1'b0) begin
        errors++; $display("FAIL rnd_ruser c%0d got %h/%b want %h/0", c, o_ruser4, o_ruser0, e_ruser); end
    end
  endtask

  initial begin
    idle_in();
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_write_read();
    test_ts();
    test_stall_stream();
    test_ts_reset();
    test_user();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
